// File: rtl/hwpe_stream_tcdm_sink_pkg.sv
// Shared types for the HWPE stream-to-TCDM write sink.
// Control/flag bundles and the sink FSM encoding.
package hwpe_stream_tcdm_sink_pkg;

    localparam int unsigned TCDM_WORD_BYTES = 4;

    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [15:0] trans_size;
    } ctrl_tcdm_sink_t;

    typedef struct packed {
        logic        ready_start;
        logic        done;
        logic [15:0] beat_cnt;
    } flags_tcdm_sink_t;

    typedef enum logic [1:0] {
        SINK_IDLE,
        SINK_WORKING,
        SINK_DONE
    } state_tcdm_sink_t;

    // Byte distance between consecutive beats.
    function automatic logic [31:0] beat_stride(
        input int unsigned nb_ports
    );
        return 32'(nb_ports * TCDM_WORD_BYTES);
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_sink_intf.sv
// TCDM word port and HWPE stream interfaces.
// Modports split master/slave and source/sink directions.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_tcdm_sink_addrgen.sv
// Beat counter and linear address generator for the TCDM sink.
// Holds the latched base/size and flags the final beat.
module hwpe_stream_tcdm_sink_addrgen
    import hwpe_stream_tcdm_sink_pkg::*;
#(
    parameter int unsigned NB_TCDM_PORTS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        beat_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] trans_size_i,
    output logic [15:0] beat_cnt_o,
    output logic [31:0] beat_addr_o,
    output logic        last_o
);

    localparam logic [31:0] STRIDE = beat_stride(NB_TCDM_PORTS);

    logic [31:0] base_q, base_d;
    logic [15:0] size_q, size_d;
    logic [15:0] cnt_q,  cnt_d;

    always_comb begin
        base_d = base_q;
        size_d = size_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            base_d = base_addr_i;
            size_d = trans_size_i;
            cnt_d  = '0;
        end else if (beat_i && (cnt_q != size_q)) begin
            // Saturate at the transfer size; never wrap.
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            size_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            base_q <= '0;
            size_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            size_q <= size_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_cnt_o  = cnt_q;
    assign beat_addr_o = base_q + ({16'b0, cnt_q} * STRIDE);
    assign last_o      = (cnt_q == (size_q - 16'd1));

endmodule

// File: rtl/hwpe_stream_tcdm_sink.sv
// HWPE stream sink: splits each beat into parallel TCDM word writes.
// A beat retires only once every port has been granted.
module hwpe_stream_tcdm_sink
    import hwpe_stream_tcdm_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hwpe_stream_intf_tcdm.master  tcdm [NB_TCDM_PORTS-1:0],
    hwpe_stream_intf_stream.sink  stream,
    input  ctrl_tcdm_sink_t       ctrl_i,
    output flags_tcdm_sink_t      flags_o
);

    state_tcdm_sink_t state_q, state_d;

    logic working;
    logic ready_start;
    logic done;
    logic ready;
    logic hs;
    logic start;
    logic last;

    logic [15:0] beat_cnt;
    logic [31:0] beat_addr;

    logic [NB_TCDM_PORTS-1:0] fence_q, fence_d;
    logic [NB_TCDM_PORTS-1:0] req;
    logic [NB_TCDM_PORTS-1:0] gnt;
    logic [NB_TCDM_PORTS-1:0] port_done;
    logic [NB_TCDM_PORTS-1:0] unused_rsp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SINK_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SINK_IDLE: begin
                if (ctrl_i.req_start) begin
                    if (ctrl_i.trans_size == '0) begin
                        state_d = SINK_DONE;
                    end else begin
                        state_d = SINK_WORKING;
                    end
                end
            end
            SINK_WORKING: begin
                if (hs && last) begin
                    state_d = SINK_DONE;
                end
            end
            SINK_DONE: state_d = SINK_IDLE;
            default:   state_d = SINK_IDLE;
        endcase
        if (clear_i) begin
            state_d = SINK_IDLE;
        end
    end

    // A soft clear drops requests in the very cycle it is seen.
    always_comb begin
        working     = 1'b0;
        ready_start = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            SINK_IDLE:    ready_start = 1'b1;
            SINK_WORKING: working     = ~clear_i;
            SINK_DONE:    done        = 1'b1;
            default:      ;
        endcase
    end

    assign start = ready_start & ctrl_i.req_start & ~clear_i;

    hwpe_stream_tcdm_sink_addrgen #(
        .NB_TCDM_PORTS (NB_TCDM_PORTS)
    ) i_addrgen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start),
        .beat_i       (hs),
        .base_addr_i  (ctrl_i.base_addr),
        .trans_size_i (ctrl_i.trans_size),
        .beat_cnt_o   (beat_cnt),
        .beat_addr_o  (beat_addr),
        .last_o       (last)
    );

    for (genvar ii = 0; ii < NB_TCDM_PORTS; ii++) begin : gen_port
        assign req[ii]        = working & stream.valid & ~fence_q[ii];
        assign gnt[ii]        = tcdm[ii].gnt;
        assign port_done[ii]  = fence_q[ii] | (req[ii] & gnt[ii]);
        assign tcdm[ii].req   = req[ii];
        assign tcdm[ii].add   = beat_addr + (32'(ii) * 32'd4);
        assign tcdm[ii].wen   = 1'b0;
        assign tcdm[ii].be    = stream.strb[4*ii +: 4];
        assign tcdm[ii].data  = stream.data[32*ii +: 32];
        assign unused_rsp[ii] = tcdm[ii].r_valid ^ (^tcdm[ii].r_data);
    end

    assign ready        = working & (&port_done);
    assign stream.ready = ready;
    assign hs           = stream.valid & ready;

    // Granted ports stay fenced until the whole beat retires.
    always_comb begin
        fence_d = fence_q;
        if (!working || hs) begin
            fence_d = '0;
        end else if (stream.valid) begin
            fence_d = port_done;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fence_q <= '0;
        end else if (clear_i) begin
            fence_q <= '0;
        end else begin
            fence_q <= fence_d;
        end
    end

    assign flags_o.ready_start = ready_start;
    assign flags_o.done        = done;
    assign flags_o.beat_cnt    = beat_cnt;

endmodule

// File: tb/tb_hwpe_stream_tcdm_sink.sv
// Randomised bench for hwpe_stream_tcdm_sink.
// Per-cycle port rules plus a per-transfer write scoreboard.
module tb_hwpe_stream_tcdm_sink;
    import hwpe_stream_tcdm_sink_pkg::*;

    localparam int DW = 64;
    localparam int NB = DW / 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    ctrl_tcdm_sink_t  ctrl;
    flags_tcdm_sink_t flags;

    hwpe_stream_intf_tcdm tcdm_if [NB-1:0] ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) st_if ();

    logic [NB-1:0] gnt;
    logic [NB-1:0] req;
    logic [NB-1:0] wen;
    logic [31:0]   add [NB];
    logic [31:0]   wd  [NB];
    logic [3:0]    be  [NB];

    for (genvar g = 0; g < NB; g++) begin : gen_tap
        assign tcdm_if[g].gnt     = gnt[g];
        assign tcdm_if[g].r_valid = 1'b0;
        assign tcdm_if[g].r_data  = '0;
        assign req[g] = tcdm_if[g].req;
        assign wen[g] = tcdm_if[g].wen;
        assign add[g] = tcdm_if[g].add;
        assign wd[g]  = tcdm_if[g].data;
        assign be[g]  = tcdm_if[g].be;
    end

    hwpe_stream_tcdm_sink #(
        .DATA_WIDTH    (DW),
        .NB_TCDM_PORTS (NB)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .tcdm    (tcdm_if),
        .stream  (st_if),
        .ctrl_i  (ctrl),
        .flags_o (flags)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] bd [64];
    logic [7:0]  bs [64];

    int          obs_cnt [bit [31:0]];
    logic [31:0] obs_dat [bit [31:0]];
    logic [3:0]  obs_be  [bit [31:0]];

    task automatic chk(
        input string       tag,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic fill_beats();
        for (int i = 0; i < 64; i++) begin
            bd[i] = {$urandom, $urandom};
            bs[i] = 8'($urandom);
        end
    endtask

    task automatic run_xfer(
        input logic [31:0] base,
        input int          size,
        input int          pv,
        input int          pg,
        input int          clr_at
    );
        logic [NB-1:0] got;
        logic [NB-1:0] ereq;
        logic [NB-1:0] edone;
        logic          v;
        logic          erdy;
        logic [31:0]   a;
        int            k;
        int            cyc;
        int            nbeat;
        bit            cleared;

        obs_cnt.delete();
        obs_dat.delete();
        obs_be.delete();
        cleared = 0;

        ctrl.req_start  = 1'b1;
        ctrl.base_addr  = base;
        ctrl.trans_size = 16'(size);
        st_if.valid     = 1'b0;
        gnt             = '0;
        #1;
        chk("start_ready", flags.ready_start, 1);
        chk("start_req", req, 0);
        @(negedge clk);
        ctrl.req_start = 1'b0;

        got = '0;
        k   = 0;
        cyc = 0;
        while (k < size && cyc < 2000 && !cleared) begin
            v = ($urandom_range(99) < pv);
            st_if.valid = v;
            st_if.data  = bd[k];
            st_if.strb  = bs[k];
            for (int i = 0; i < NB; i++)
                gnt[i] = ($urandom_range(99) < pg);
            ctrl.req_start  = ($urandom_range(7) == 0);
            ctrl.base_addr  = $urandom;
            ctrl.trans_size = 16'($urandom);
            if (k == clr_at) begin
                clear = 1'b1;
                #1;
                chk("clr_req_now", req, 0);
                chk("clr_rdy_now", st_if.ready, 0);
                @(negedge clk);
                clear       = 1'b0;
                st_if.valid = 1'b0;
                ctrl.req_start = 1'b0;
                #1;
                chk("clr_ready_start", flags.ready_start, 1);
                chk("clr_cnt", flags.beat_cnt, 0);
                chk("clr_done", flags.done, 0);
                chk("clr_req", req, 0);
                @(negedge clk);
                #1;
                chk("clr_done2", flags.done, 0);
                @(negedge clk);
                cleared = 1;
            end else begin
                #1;
                for (int i = 0; i < NB; i++) begin
                    ereq[i]  = v & ~got[i];
                    edone[i] = got[i] | (ereq[i] & gnt[i]);
                end
                erdy = v & (&edone);
                chk("req", req, ereq);
                chk("ready", st_if.ready, erdy);
                chk("beat_cnt", flags.beat_cnt, 64'(k));
                chk("done_busy", flags.done, 0);
                chk("wen", wen, 0);
                for (int i = 0; i < NB; i++) begin
                    if (ereq[i]) begin
                        a = base + 32'(k * NB * 4) + 32'(i * 4);
                        chk("add", add[i], a);
                    end
                    if (req[i] && gnt[i]) begin
                        if (obs_cnt.exists(add[i]))
                            obs_cnt[add[i]]++;
                        else
                            obs_cnt[add[i]] = 1;
                        obs_dat[add[i]] = wd[i];
                        obs_be[add[i]]  = be[i];
                    end
                end
                if (erdy) begin
                    k++;
                    got = '0;
                end else if (v) begin
                    got = edone;
                end
                @(negedge clk);
                cyc++;
            end
        end

        if (!cleared) begin
            chk("xfer_budget", 64'(cyc < 2000), 1);
            if (pv == 100 && pg == 100)
                chk("fullrate_cycles", cyc, size);
            // DONE cycle: a start request here must be ignored.
            ctrl.req_start  = 1'b1;
            ctrl.base_addr  = $urandom;
            ctrl.trans_size = 16'($urandom_range(1, 9));
            st_if.valid     = 1'b1;
            gnt             = '1;
            #1;
            chk("done_pulse", flags.done, 1);
            chk("done_rs", flags.ready_start, 0);
            chk("done_req", req, 0);
            chk("done_rdy", st_if.ready, 0);
            chk("done_cnt", flags.beat_cnt, 64'(size));
            @(negedge clk);
            ctrl.req_start = 1'b0;
            st_if.valid    = 1'b0;
            #1;
            chk("idle_done", flags.done, 0);
            chk("idle_rs", flags.ready_start, 1);
            chk("idle_req", req, 0);
            chk("idle_cnt", flags.beat_cnt, 64'(size));
            @(negedge clk);
            nbeat = size;
        end else begin
            nbeat = clr_at;
        end

        for (int kk = 0; kk < nbeat; kk++) begin
            for (int i = 0; i < NB; i++) begin
                a = base + 32'(kk * NB * 4) + 32'(i * 4);
                if (!obs_cnt.exists(a)) begin
                    chk("sb_written", 0, 1);
                end else begin
                    chk("sb_once", obs_cnt[a], 1);
                    chk("sb_data", obs_dat[a], bd[kk][32*i +: 32]);
                    chk("sb_be", obs_be[a], bs[kk][4*i +: 4]);
                end
            end
        end
    endtask

    initial begin
        ctrl        = '0;
        st_if.valid = 1'b0;
        st_if.data  = '0;
        st_if.strb  = '0;
        gnt         = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready_start", flags.ready_start, 1);
        chk("rst_done", flags.done, 0);
        chk("rst_cnt", flags.beat_cnt, 0);
        chk("rst_req", req, 0);
        chk("rst_rdy", st_if.ready, 0);
        chk("rst_add0", add[0], 0);
        chk("rst_add1", add[1], 4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill_beats();
        run_xfer(32'h1000, 4, 100, 100, -1);

        fill_beats();
        bd[0] = 64'hAABBCCDD_11223344;
        bs[0] = 8'hF0;
        run_xfer(32'h2000, 1, 100, 100, -1);

        fill_beats();
        run_xfer(32'h3000, 6, 100, 40, -1);

        fill_beats();
        run_xfer(32'h4000, 3, 50, 100, -1);

        run_xfer(32'h5000, 0, 100, 100, -1);

        fill_beats();
        run_xfer(32'h6000, 8, 100, 100, 2);

        fill_beats();
        run_xfer(32'hFFFF_FFF0, 5, 80, 70, -1);

        for (int t = 0; t < 20; t++) begin
            fill_beats();
            run_xfer({$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) * 4),
                     $urandom_range(0, 20),
                     $urandom_range(30, 100),
                     $urandom_range(30, 100),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_tcdm_sink.md
# hwpe_stream_tcdm_sink

Write-side counterpart of the HWPE stream source. It accepts a `DATA_WIDTH`-bit HWPE stream and splits each beat into `NB_TCDM_PORTS` parallel 32-bit TCDM write requests at linearly incrementing, word-aligned addresses. A start/done FSM controls it, and it sits between an HWPE datapath output and the shared TCDM interconnect. Each port keeps its own grant fence, so a beat is consumed only once every port has been granted; per-port grants may arrive in different cycles.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream width in bits; must be a multiple of 32.
- `NB_TCDM_PORTS`, `DATA_WIDTH/32`: number of TCDM master ports.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous soft clear; same effect as reset.
- `tcdm[NB_TCDM_PORTS-1:0]`, `hwpe_stream_intf_tcdm.master`: word write ports (`req`, `add`, `wen`, `be`, `data`, `gnt`; `r_valid` and `r_data` are ignored).
- `stream`, `hwpe_stream_intf_stream.sink`, `DATA_WIDTH`: input data with `strb` of `DATA_WIDTH/8` bits.
- `ctrl_i`, in, `ctrl_tcdm_sink_t`: fields `req_start`, `base_addr[31:0]` and `trans_size[15:0]` (number of beats).
- `flags_o`, out, `flags_tcdm_sink_t`: fields `ready_start`, `done` and `beat_cnt[15:0]`.

## Operation
FSM states are `SINK_IDLE`, `SINK_WORKING` and `SINK_DONE`.

- **SINK_IDLE**
  - `ready_start=1`.
  - On `req_start`: latch `base_addr` and `trans_size`, clear `beat_cnt`, go to WORKING.
  - If the latched `trans_size==0`, go to DONE instead.
- **SINK_WORKING**
  - Per port ii:
    - `req[ii] = stream.valid & ~fence_q[ii]`.
    - `add = base_q + beat_cnt*NB_TCDM_PORTS*4 + ii*4`, 32-bit wrap-around.
    - `wen=0` (write).
    - `be = stream.strb[4*ii+:4]`.
    - `data = stream.data[32*ii+:32]`.
  - `port_done[ii] = fence_q[ii] | (req[ii] & gnt[ii])`.
  - `stream.ready = &port_done` (combinational, and only in WORKING).
  - On a handshake (`valid & ready`):
    - clear `fence_q` and increment `beat_cnt`.
    - If `beat_cnt == trans_size_q-1`, go to DONE.
  - Without a handshake: `fence_q[ii] <= port_done[ii]` for ports with `valid=1`. A granted port never re-requests the same beat.
- **SINK_DONE**: `flags_o.done=1` for exactly this one cycle, then unconditionally go to IDLE.
- **Outside WORKING**: `stream.ready=0` and all `req=0`.
- **Stream contract**: the upstream source must not change data or strb while `valid=1` and `ready=0`.
- **Boundary rules**
  - A `req_start` during WORKING or DONE is ignored.
  - With `strb` all zero, the port still issues a request with `be=0`.
  - `beat_cnt` saturates logically at `trans_size_q`; it never wraps within a transfer.
  - `clear_i` or reset mid-transfer: state goes to IDLE, `fence_q`, `beat_cnt`, `base_q` and `trans_size_q` go to 0, and all `req` drop in the same cycle for `clear_i`, or immediately for reset.

## Timing
- **Reset values**
  - `flags_o.ready_start=1`, since the block is in IDLE.
  - `flags_o.done=0`, `flags_o.beat_cnt=0`.
  - all `tcdm.req=0`; `tcdm.add=base_q=0`, so `add=ii*4` per port; `be`, `data` and `wen` follow the port assignments above.
  - `stream.ready=0`.
- **Start**: `req_start` is sampled at edge T; WORKING is entered and requests are possible from cycle T+1.
- **Full-grant throughput**: when all grants are high with the request, one beat per cycle is consumed. The first beat's requests are issued and granted in cycle T+1.
- **Latency**: requests are combinational from `stream.valid`, with zero-cycle request latency. Nothing is registered on the data path.
- **Skewed grants**: the beat completes in the cycle the last outstanding port is granted.
- **Last beat**: if the last handshake occurs in cycle N, `done=1` in N+1 (DONE) and `ready_start=1` in N+2 (IDLE).
- **`trans_size=0`**: start at T, DONE at T+1, IDLE at T+2; no TCDM request is issued.

## Structure
- `hwpe_stream_package` gains `ctrl_tcdm_sink_t`, `flags_tcdm_sink_t`, and the `state_tcdm_sink_t` enum (IDLE/WORKING/DONE).
- A natural sub-module is `hwpe_stream_tcdm_sink_addrgen`, holding `base_q`, `trans_size_q`, `beat_cnt` and the last-beat flag. The per-port fence and request/data binding go in a generate loop in the top module.

## Test plan
- **Full grant**: `DATA_WIDTH=64`, base `0x1000`, `trans_size=4`, all `gnt=1`, stream valid every cycle. Expect four consecutive beats with `tcdm[0].add` = 0x1000, 0x1008, 0x1010, 0x1018 and `tcdm[1].add` = `tcdm[0].add+4`. `done` pulses exactly once, one cycle after the 4th handshake.
- **Skewed grants**: `gnt[0]=1` in cycle 1 and `gnt[1]=1` only in cycle 3. Expect `req[0]` low in cycles 2–3, `stream.ready` high only in cycle 3, and port 0 written once.
- **Strobe pass-through**: beat with `strb=8'hF0` and data `0xAABBCCDD_11223344`. Expect `tcdm[0].be=0` with data `0x11223344`, and `tcdm[1].be=0xF` with data `0xAABBCCDD`.
- **Backpressure**: `stream.valid` toggles 1-0-1 with `trans_size=3` and all grants high. Expect no requests in valid-low cycles, `beat_cnt` of 1 then 2 then 3, and addresses contiguous.
- **Zero size and ignored start**: `trans_size=0` gives `done` at T+1 with no request. A `req_start` asserted during WORKING leaves `beat_cnt` and addresses unchanged.
- **Mid-transfer clear**: `clear_i` after 2 of 8 beats. Expect all requests low, `ready_start=1` and `beat_cnt=0` the next cycle, and `done` never asserted.
